tmr_fault_manager: RTL and testbench

TMR_FAULT_MANAGER -- requirements
Module: tmr_fault_manager

---
 rtl/tmr_fault_manager_if.sv | 26 ++
 rtl/tmr_fault_manager.sv | 118 +++++++++++
 tb/tb_tmr_fault_manager.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/tmr_fault_manager_if.sv
// Bus between the TMR voter/decode stage and the fault manager.
// The slave side is the fault manager itself; the master side drives voter results.
interface tmr_fault_manager_if #(
  parameter int CNT_W = 8
);
  logic             valid_i;
  logic [2:0]       fault_i;
  logic [2:0]       repl_err_i;
  logic             clear_i;
  logic             stall_o;
  logic             retry_o;
  logic [CNT_W-1:0] transient_cnt_o;
  logic             perm_fault_o;
  logic [2:0]       faulty_replica_o;
  logic             irq_o;

  modport slave (
    input  valid_i, fault_i, repl_err_i, clear_i,
    output stall_o, retry_o, transient_cnt_o, perm_fault_o, faulty_replica_o, irq_o
  );

  modport master (
    output valid_i, fault_i, repl_err_i, clear_i,
    input  stall_o, retry_o, transient_cnt_o, perm_fault_o, faulty_replica_o, irq_o
  );
endinterface

// File: rtl/tmr_fault_manager.sv
// Fault manager for a triplicated decoder: retries a disagreeing decode a bounded
// number of times, counts recovered faults and latches a permanent fault with an alarm.
module tmr_fault_manager #(
  parameter int CNT_W     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                clk,
  input  logic                rst,
  tmr_fault_manager_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RETRY = 2'd1,
    CHECK = 2'd2,
    PERM  = 2'd3
  } state_e;

  localparam logic [2:0] LastRetry = 3'(MAX_RETRY - 1);

  state_e           state_q, state_d;
  logic [2:0]       retry_q, retry_d;
  logic [2:0]       episode_q, episode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic             detect;

  assign detect = bus.valid_i && (bus.fault_i != 3'b000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      retry_q   <= 3'd0;
      episode_q <= 3'd0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      episode_q <= episode_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    episode_d = episode_q;
    cnt_d     = cnt_q;
    irq_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_i) cnt_d = '0;
        if (detect) begin
          state_d   = RETRY;
          retry_d   = 3'd0;
          episode_d = bus.repl_err_i;
        end
      end
      RETRY: state_d = CHECK;
      CHECK: begin
        // fault_i is sampled here even without valid_i: the stage is stalled on the re-decode
        if (bus.fault_i == 3'b000) begin
          state_d = IDLE;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end else if (retry_q < LastRetry) begin
          state_d   = RETRY;
          retry_d   = retry_q + 3'd1;
          episode_d = episode_q | bus.repl_err_i;
        end else begin
          state_d   = PERM;
          episode_d = episode_q | bus.repl_err_i;
          irq_d     = 1'b1;
        end
      end
      PERM: begin
        if (bus.clear_i) begin
          state_d   = IDLE;
          episode_d = 3'd0;
          cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall_o          = 1'b0;
    bus.retry_o          = 1'b0;
    bus.perm_fault_o     = 1'b0;
    bus.irq_o            = 1'b0;
    bus.faulty_replica_o = 3'b000;
    if (!rst) begin
      case (state_q)
        IDLE:  bus.stall_o = detect;
        RETRY: begin
          bus.stall_o          = 1'b1;
          bus.retry_o          = 1'b1;
          bus.faulty_replica_o = episode_q;
        end
        CHECK: begin
          bus.stall_o          = 1'b1;
          bus.faulty_replica_o = episode_q;
        end
        PERM: begin
          bus.perm_fault_o     = 1'b1;
          bus.irq_o            = irq_q;
          bus.faulty_replica_o = episode_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.transient_cnt_o = cnt_q;

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Scoreboard bench for tmr_fault_manager: directed episodes then random traffic,
// checked against an episode-step reference model.
module tb_tmr_fault_manager;

  localparam int CW = 2;
  localparam int MR = 2;

  logic clk;
  logic rst;

  tmr_fault_manager_if #(.CNT_W(CW)) bus ();

  tmr_fault_manager #(.CNT_W(CW), .MAX_RETRY(MR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic          stall;
    logic          retry;
    logic          perm;
    logic          irq;
    logic [2:0]    faulty;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // Model: an episode is a numbered sequence of steps after detection; odd steps
  // re-decode, even steps judge the outcome, and the MR-th failed judgement is permanent.
  bit mBusy = 0;
  bit mPerm = 0;
  bit mIrq  = 0;
  int mStep = 0;
  int mMask = 0;
  int mCount = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [2:0] f,
                               input logic [2:0] e, input logic c);
    exp_t x;
    @(posedge clk);
    #1;
    rst            = r;
    bus.valid_i    = v;
    bus.fault_i    = f;
    bus.repl_err_i = e;
    bus.clear_i    = c;

    x.stall  = 1'b0;
    x.retry  = 1'b0;
    x.perm   = 1'b0;
    x.irq    = 1'b0;
    x.faulty = 3'b000;
    x.cnt    = CW'(mCount);
    if (!r) begin
      if (mPerm) begin
        x.perm   = 1'b1;
        x.irq    = mIrq;
        x.faulty = 3'(mMask);
      end else if (mBusy) begin
        x.stall  = 1'b1;
        x.retry  = (mStep % 2) == 1;
        x.faulty = 3'(mMask);
      end else begin
        x.stall = v && (f != 3'b000);
      end
    end
    expQ.push_back(x);

    if (r) begin
      mBusy = 0; mPerm = 0; mIrq = 0; mMask = 0; mCount = 0;
    end else if (mPerm) begin
      mIrq = 0;
      if (c) begin
        mPerm = 0; mMask = 0; mCount = 0;
      end
    end else if (mBusy) begin
      mIrq = 0;
      if (mStep % 2 == 1) begin
        mStep++;
      end else if (f == 3'b000) begin
        mBusy = 0;
        if (mCount < (1 << CW) - 1) mCount++;
      end else begin
        mMask = mMask | int'(e);
        if (mStep / 2 == MR) begin
          mBusy = 0; mPerm = 1; mIrq = 1;
        end else begin
          mStep++;
        end
      end
    end else begin
      mIrq = 0;
      if (c) mCount = 0;
      if (v && f != 3'b000) begin
        mBusy = 1; mStep = 1; mMask = int'(e);
      end
    end
  endtask

  task automatic transientEpisode();
    applyStimulus(1'b0, 1'b1, 3'b001, 3'b010, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        exp_t x;
        x = expQ.pop_front();
        checkOutput("stall_o",          int'(bus.stall_o),          int'(x.stall));
        checkOutput("retry_o",          int'(bus.retry_o),          int'(x.retry));
        checkOutput("perm_fault_o",     int'(bus.perm_fault_o),     int'(x.perm));
        checkOutput("irq_o",            int'(bus.irq_o),            int'(x.irq));
        checkOutput("faulty_replica_o", int'(bus.faulty_replica_o), int'(x.faulty));
        checkOutput("transient_cnt_o",  int'(bus.transient_cnt_o),  int'(x.cnt));
        if (bus.retry_o && bus.irq_o) checkOutput("retry_irq_exclusive", 1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drain;
    rst            = 1'b1;
    bus.valid_i    = 1'b0;
    bus.fault_i    = 3'b000;
    bus.repl_err_i = 3'b000;
    bus.clear_i    = 1'b0;
    repeat (2) applyStimulus(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);

    // Single transient fault recovered on the first re-decode
    transientEpisode();
    @(negedge clk);
    checkOutput("transient_cnt_after_one", int'(bus.transient_cnt_o), 1);
    checkOutput("faulty_replica_idle",     int'(bus.faulty_replica_o), 0);
    checkOutput("stall_released",          int'(bus.stall_o), 0);

    // Held fault escalates to permanent
    repeat (5) applyStimulus(1'b0, 1'b1, 3'b100, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    checkOutput("perm_at_t5",  int'(bus.perm_fault_o), 1);
    checkOutput("irq_at_t5",   int'(bus.irq_o), 1);
    checkOutput("stall_at_t5", int'(bus.stall_o), 0);
    applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);

    // Replica masks accumulate across a permanent episode, then clear
    applyStimulus(1'b0, 1'b1, 3'b001, 3'b001, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b100, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b111, 3'b010, 1'b0);
    @(negedge clk);
    checkOutput("faulty_replica_perm", int'(bus.faulty_replica_o), 5);
    applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    checkOutput("perm_cleared", int'(bus.perm_fault_o), 0);
    checkOutput("cnt_cleared",  int'(bus.transient_cnt_o), 0);

    // Counter saturation
    repeat (5) transientEpisode();
    @(negedge clk);
    checkOutput("cnt_saturated", int'(bus.transient_cnt_o), 3);

    // Reset during CHECK, then a fault without valid_i
    applyStimulus(1'b0, 1'b1, 3'b010, 3'b001, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b010, 3'b000, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b101, 3'b011, 1'b0);
    @(negedge clk);
    checkOutput("no_stall_without_valid", int'(bus.stall_o), 0);
    checkOutput("no_irq_after_reset",     int'(bus.irq_o), 0);
    checkOutput("cnt_after_reset",        int'(bus.transient_cnt_o), 0);

    for (int i = 0; i < 1500; i++) begin
      logic       r, v, c;
      logic [2:0] f, e;
      r = ($urandom_range(0, 59) == 0);
      v = $urandom_range(0, 1) == 1;
      f = ($urandom_range(0, 9) < 4) ? 3'($urandom_range(1, 7)) : 3'b000;
      e = 3'($urandom_range(0, 7));
      c = ($urandom_range(0, 9) == 0);
      applyStimulus(r, v, f, e, c);
    end

    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (expQ.size() > 0) checkOutput("scoreboard_drain", expQ.size(), 0);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
